// File: rtl/cordic_exp_iter_if.sv
// ============================================================================
// Module   : cordic_exp_iter_if
// Purpose  : start/busy/done handshake and result bus of the CORDIC exp unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cordic_exp_iter_if;
  logic        start;
  logic [31:0] z_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] cosh_out;
  logic [31:0] sinh_out;
  logic [31:0] exp_out;

  modport master (
    output start, z_in,
    input  busy, done, err, cosh_out, sinh_out, exp_out
  );

  modport slave (
    input  start, z_in,
    output busy, done, err, cosh_out, sinh_out, exp_out
  );
endinterface

`default_nettype wire

// File: rtl/cordic_exp_iter.sv
// ============================================================================
// Module   : cordic_exp_iter
// Purpose  : iterative hyperbolic rotation-mode CORDIC giving cosh/sinh/exp
//            of a sign-magnitude Q15.16 argument, one micro-rotation a clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cordic_exp_iter #(
  parameter int ITER = 16,
  parameter int FRAC = 16,
  parameter int ZMAX = 73277
) (
  input wire logic          clk,
  input wire logic          rst,
  cordic_exp_iter_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [31:0] INV_KH = 32'h0001351F << (FRAC - 16);

  // Sign-magnitude words go through a 33-bit two's-complement sum; the
  // result is mapped back with zero always carrying a positive sign.
  function automatic logic signed [32:0] to_tc(input logic [31:0] v);
    logic signed [32:0] m;
    m = $signed({2'b00, v[30:0]});
    return v[31] ? -m : m;
  endfunction

  function automatic logic [31:0] to_sm(input logic signed [32:0] v);
    return {v[32], 31'(v[32] ? -v : v)};
  endfunction

  function automatic logic [31:0] sm_add(input logic [31:0] a, input logic [31:0] b);
    return to_sm(to_tc(a) + to_tc(b));
  endfunction

  function automatic logic [30:0] atanh_rom(input logic [5:0] i);
    logic [30:0] v;
    case (i)
      6'd1:    v = 31'd35999;
      6'd2:    v = 31'd16739;
      6'd3:    v = 31'd8235;
      6'd4:    v = 31'd4101;
      6'd5:    v = 31'd2049;
      6'd6:    v = 31'd1024;
      6'd7:    v = 31'd512;
      6'd8:    v = 31'd256;
      6'd9:    v = 31'd128;
      6'd10:   v = 31'd64;
      6'd11:   v = 31'd32;
      6'd12:   v = 31'd16;
      6'd13:   v = 31'd8;
      6'd14:   v = 31'd4;
      6'd15:   v = 31'd2;
      6'd16:   v = 31'd1;
      6'd17:   v = 31'd1;
      default: v = 31'd0;
    endcase
    return v << (FRAC - 16);
  endfunction

  // Hyperbolic CORDIC only converges when indices 4, 13, 40 ... are repeated.
  function automatic logic is_repeat_idx(input logic [5:0] i);
    return (i == 6'd4) || (i == 6'd13) || (i == 6'd40);
  endfunction

  logic [1:0]  r_state;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [31:0] r_z;
  logic [5:0]  r_shift;
  logic        r_rep;
  logic        r_range_err;

  logic [30:0] w_zmag;
  logic        w_dneg;
  logic [31:0] w_xt;
  logic [31:0] w_yt;
  logic [31:0] w_zt;
  logic [31:0] w_x_next;
  logic [31:0] w_y_next;
  logic [31:0] w_z_next;
  logic [31:0] w_exp;
  logic        w_repeat_now;
  logic        w_last;

  always_comb begin
    w_zmag       = bus.z_in[30:0];
    w_dneg       = r_z[31];
    w_xt         = {r_y[31] ^ w_dneg, r_y[30:0] >> r_shift};
    w_yt         = {r_x[31] ^ w_dneg, r_x[30:0] >> r_shift};
    // z - d*atanh: the table term is subtracted when d = +1
    w_zt         = {~w_dneg, atanh_rom(r_shift)};
    w_x_next     = sm_add(r_x, w_xt);
    w_y_next     = sm_add(r_y, w_yt);
    w_z_next     = sm_add(r_z, w_zt);
    w_exp        = sm_add(r_x, r_y);
    w_repeat_now = is_repeat_idx(r_shift) && !r_rep;
    w_last       = (r_shift == 6'(ITER)) && !w_repeat_now;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_x          <= 32'd0;
      r_y          <= 32'd0;
      r_z          <= 32'd0;
      r_shift      <= 6'd0;
      r_rep        <= 1'b0;
      r_range_err  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.cosh_out <= 32'd0;
      bus.sinh_out <= 32'd0;
      bus.exp_out  <= 32'd0;
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            bus.err  <= 1'b0;
            r_shift  <= 6'd1;
            r_rep    <= 1'b0;
            r_y      <= 32'd0;
            if (w_zmag > 31'(ZMAX)) begin
              r_x         <= 32'd0;
              r_z         <= 32'd0;
              r_range_err <= 1'b1;
              r_state     <= S_FIN;
            end else begin
              r_x         <= INV_KH;
              // a negative zero argument is folded to +0 so d starts at +1
              r_z         <= (w_zmag == 31'd0) ? 32'd0 : bus.z_in;
              r_range_err <= 1'b0;
              r_state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_x <= w_x_next;
          r_y <= w_y_next;
          r_z <= w_z_next;
          if (w_last) begin
            r_state <= S_FIN;
          end else if (w_repeat_now) begin
            r_rep <= 1'b1;
          end else begin
            r_shift <= r_shift + 6'd1;
            r_rep   <= 1'b0;
          end
        end
        S_FIN: begin
          bus.cosh_out <= r_x;
          bus.sinh_out <= r_y;
          bus.exp_out  <= w_exp;
          bus.err      <= r_range_err;
          bus.done     <= 1'b1;
          bus.busy     <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cordic_exp_iter.sv
// ============================================================================
// Module   : tb_cordic_exp_iter
// Purpose  : directed and random checks of cordic_exp_iter against an
//            integer-domain reference model through a scoreboard queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cordic_exp_iter;

  localparam int ZMAX = 73277;

  typedef struct {
    logic [31:0] c;
    logic [31:0] s;
    logic [31:0] e;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cordic_exp_iter_if bus();

  cordic_exp_iter #(.ITER(16), .FRAC(16), .ZMAX(ZMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int atanh_tab [17] = '{0, 35999, 16739, 8235, 4101, 2049, 1024, 512, 256,
                         128, 64, 32, 16, 8, 4, 2, 1};

  function automatic longint sm2int(input logic [31:0] v);
    longint m;
    m = longint'({33'd0, v[30:0]});
    return v[31] ? -m : m;
  endfunction

  function automatic logic [31:0] int2sm(input longint v);
    logic [63:0] m;
    m = (v < 0) ? -v : v;
    return {(v < 0), m[30:0]};
  endfunction

  function automatic longint tshift(input longint v, input int i);
    return (v < 0) ? -((-v) >> i) : (v >> i);
  endfunction

  function automatic exp_t model(input logic [31:0] z);
    exp_t   r;
    longint x, y, zz, xs, ys;
    if (z[30:0] > 31'(ZMAX)) begin
      r.c = 32'd0; r.s = 32'd0; r.e = 32'd0; r.err = 1'b1;
      return r;
    end
    x  = 79135;
    y  = 0;
    zz = sm2int(z);
    for (int i = 1; i <= 16; i++) begin
      for (int k = 0; k < ((i == 4 || i == 13) ? 2 : 1); k++) begin
        xs = tshift(y, i);
        ys = tshift(x, i);
        if (zz >= 0) begin
          x += xs; y += ys; zz -= atanh_tab[i];
        end else begin
          x -= xs; y -= ys; zz += atanh_tab[i];
        end
      end
    end
    r.c = int2sm(x); r.s = int2sm(y); r.e = int2sm(x + y); r.err = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_tol(input string tag, input longint obs, input longint expv, input longint tol);
    checks++;
    assert ((obs - expv) <= tol && (expv - obs) <= tol) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, expv, tol);
    end
  endtask

  task automatic pop_and_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_cosh"}, bus.cosh_out, e.c);
      chk({tag, "_sinh"}, bus.sinh_out, e.s);
      chk({tag, "_exp"},  bus.exp_out,  e.e);
      chk({tag, "_err"},  {31'd0, bus.err}, {31'd0, e.err});
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] z, input int exp_lat);
    int lat;
    sb.push_back(model(z));
    @(negedge clk);
    bus.start = 1'b1;
    bus.z_in  = z;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    pop_and_check(tag);
  endtask

  initial begin
    int          ndone;
    logic [31:0] z;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.z_in  = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);
    chk("rst_cosh", bus.cosh_out, 32'd0);
    chk("rst_sinh", bus.sinh_out, 32'd0);
    chk("rst_exp",  bus.exp_out,  32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("zero", 32'h00000000, 19);
    chk_tol("zero_cosh_tol", sm2int(bus.cosh_out), 65536, 8);
    chk_tol("zero_sinh_tol", sm2int(bus.sinh_out), 0, 8);
    chk_tol("zero_exp_tol",  sm2int(bus.exp_out), 65536, 8);
    run_op("negzero", 32'h80000000, 19);

    run_op("pos1", 32'h00010000, 19);
    chk_tol("pos1_cosh_tol", sm2int(bus.cosh_out), 101127, 8);
    chk_tol("pos1_sinh_tol", sm2int(bus.sinh_out), 77018, 8);
    chk_tol("pos1_exp_tol",  sm2int(bus.exp_out), 178145, 16);

    run_op("neg1", 32'h80010000, 19);
    chk_tol("neg1_cosh_tol", sm2int(bus.cosh_out), 101127, 8);
    chk_tol("neg1_sinh_tol", sm2int(bus.sinh_out), -77018, 8);
    chk_tol("neg1_exp_tol",  sm2int(bus.exp_out), 24109, 16);

    run_op("range", 32'h00020000, 1);
    run_op("clr", 32'h00010000, 19);
    run_op("zmax", 32'(ZMAX), 19);
    run_op("zmaxn", 32'h80000000 | 32'(ZMAX), 19);
    run_op("zmax1", 32'(ZMAX + 1), 1);

    // start held high: one result every 20 cycles
    repeat (3) sb.push_back(model(32'h00010000));
    @(negedge clk);
    bus.start = 1'b1;
    bus.z_in  = 32'h00010000;
    ndone = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 50) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        chk("held_pos", 32'(k), 32'(19 + 20 * (ndone - 1)));
        pop_and_check("held");
      end
    end
    chk("held_count", 32'(ndone), 32'd3);

    // second start pulse in the middle of a run is dropped
    sb.push_back(model(32'h00008000));
    @(negedge clk);
    bus.start = 1'b1;
    bus.z_in  = 32'h00008000;
    ndone = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (k == 4) begin
        bus.start = 1'b1;
        bus.z_in  = 32'h80018000;
      end
      if (k == 5) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        chk("mid_pos", 32'(k), 32'd19);
        pop_and_check("mid");
      end
    end
    chk("mid_count", 32'(ndone), 32'd1);

    // reset in the middle of a run aborts it
    @(negedge clk);
    bus.start = 1'b1;
    bus.z_in  = 32'h00010000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_flags", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);
    chk("arst_cosh", bus.cosh_out, 32'd0);
    chk("arst_sinh", bus.sinh_out, 32'd0);
    chk("arst_exp",  bus.exp_out,  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("arst_nodone", 32'(ndone), 32'd0);
    run_op("after_rst", 32'h00010000, 19);

    for (int n = 0; n < 500; n++) begin
      z = {1'($urandom_range(0, 1)), 31'($urandom_range(0, ZMAX))};
      run_op("rand", z, 19);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
